mode_stopwatch: RTL and testbench
=================================

# mode_stopwatch

Stopwatch display mode feeding the mode-select mux ahead of the LCD driver, selected when `dip_sw` = 4'b0100. It counts MM:SS.CC time from an internally derived 100 Hz enable and is controlled by the debounced push-buttons. It answers the LCD driver's character-index scan with one ASCII byte per position of the 2x16 display.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency; `CLK_HZ/100` must be an integer ≥ 2.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset; one clock; asynchronous and active-low.
- `sw_in`  in  4  debounced button levels, active-high: [0] start/stop, [1] lap/clear, [3:2] ignored.
- `index`  in  5  LCD character position: 0–15 is line 1, 16–31 is line 2.
- `out`  out  8  ASCII character for `index`.
- `running`  out  1  high in states RUN and LAP.

## Operation
- Edge detect: each `sw_in` bit is registered. A press is a 0→1 transition and acts once. Held levels are ignored.
- State machine states: IDLE, RUN, LAP, STOP.
  - IDLE: time is 00:00.00. A start press goes to RUN.
  - RUN: counting. A start press goes to STOP. A lap press captures the live time into the lap register and goes to LAP.
  - LAP: counting continues; the display shows the frozen lap register. A lap press re-captures and stays in LAP. A start press goes to STOP, and the display returns to live time.
  - STOP: time is frozen. A start press resumes in RUN from the held time. A lap press clears time and lap to zero and goes to IDLE.
- Simultaneous start and lap presses in one cycle: start wins and lap is dropped.
- Time is BCD: cc 00–99, ss 00–59, mm 00–99. cc wraps 99→00 and carries to ss. ss wraps 59→00 and carries to mm.
- Saturation: a tick at 99:59.99 leaves the time unchanged and forces STOP.
- Display text:
  - Index 0–9: "STOPWATCH ". Index 10–11: spaces.
  - Index 12–15: "IDLE", "RUN ", "LAP " or "STOP".
  - Index 16–17: spaces. 18–19: mm. 20: ':'. 21–22: ss. 23: '.'. 24–25: cc. 26–31: spaces.
  - Digits are encoded as 8'h30 + BCD value.

## Timing
- Reset values: `out` = 8'h20, `running` = 0, state IDLE, time and lap = 0, prescaler = 0, edge registers = 0.
- Press latency: a rising edge on `sw_in` in cycle n is registered at edge n+1. The state changes at edge n+2.
- Prescaler:
  - Counts 0..CLK_HZ/100−1 only in RUN or LAP. It emits a one-cycle tick at terminal count.
  - It is cleared on every entry to RUN. The first cc increment therefore falls exactly CLK_HZ/100 cycles after that entry.
  - It holds its value in STOP. It is cleared in IDLE.
- A tick coincident with a stop press: the tick is applied, then the state becomes STOP.
- A tick coincident with a lap capture: the lap register captures the pre-increment value.
- `out` is registered: `index` in cycle n appears on `out` after edge n+1. An `index` value of 32 or more cannot occur; all 5-bit values are still decoded.
- `running` is a registered decode of the state.
- Reset asserted mid-count: all state clears immediately and asynchronously.

## Configuration
- `MODE_STOPWATCH_LAP_EN` defined: the lap register and LAP state are built, and lap behaves as above.
- Not defined:
  - No lap register and no LAP state.
  - A lap press in RUN is ignored.
  - A lap press in STOP still clears to IDLE.
  - The status text never shows "LAP ".

## Structure
- Shared package `mode_stopwatch_pkg`:
  - state enum (IDLE, RUN, LAP, STOP)
  - ASCII constants: space, ':', '.', '0'
  - the four 4-character status strings
  - index constants: status start 12, mm 18, ss 21, cc 24
- One sub-module, `stopwatch_counter`: prescaler plus BCD cc/ss/mm chain with saturation.
  - Inputs: `clk`, `rst`, `run`, `clear`, `restart`.
  - Outputs: the 24-bit BCD time and a saturation flag.
- The top holds the edge detect, the FSM, the lap register and the character mux.

## Test plan
All scenarios use `CLK_HZ` = 1000, so the prescaler period is 10 cycles.
- Reset, then scan `index` 0–31 → line 1 reads "STOPWATCH   IDLE", line 2 reads "  00:00.00      ", and `running` = 0.
- Start press, then wait 10×123 cycles → the display shows 00:01.23 with status "RUN ". Check the carry at cc 99→00 and at ss 59→00 with mm increment.
- In RUN, press lap at 00:02.50, then run 500 more cycles → line 2 holds 00:02.50. Then press start → STOP shows 00:03.00, and `running` drops.
- In STOP, press lap → time clears and the status reads "IDLE". Then drive start and lap edges in the same cycle from IDLE → the state goes to RUN with no clear.
- Preload or run to 99:59.99, then wait 10 cycles → the time stays at 99:59.99 and the state is STOP. Assert `rst` mid-count → `out` = 8'h20 asynchronously.
- Build without `MODE_STOPWATCH_LAP_EN`: a lap press in RUN → no change and counting continues.

Source files
------------

// File: rtl/mode_stopwatch_pkg.sv
// Shared types and constants for the stopwatch display mode.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mode_stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    localparam logic [31:0] STR_IDLE  = "IDLE";
    localparam logic [31:0] STR_RUN   = "RUN ";
    localparam logic [31:0] STR_LAP   = "LAP ";
    localparam logic [31:0] STR_STOP  = "STOP";
    localparam logic [79:0] STR_TITLE = "STOPWATCH ";

    localparam logic [4:0] IDX_STATUS = 5'd12;
    localparam logic [4:0] IDX_MM     = 5'd18;
    localparam logic [4:0] IDX_SS     = 5'd21;
    localparam logic [4:0] IDX_CC     = 5'd24;

    // Time layout: {mm_hi, mm_lo, ss_hi, ss_lo, cc_hi, cc_lo}, one BCD nibble each.
    localparam logic [23:0] TIME_MAX = 24'h995999;

    // Advance MM:SS.CC by one hundredth; callers guard the 99:59.99 case.
    function automatic logic [23:0] bcd_time_inc(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd9) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) begin
                        r[15:12] = t[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        if (t[19:16] != 4'd9) begin
                            r[19:16] = t[19:16] + 4'd1;
                        end else begin
                            r[19:16] = 4'd0;
                            r[23:20] = t[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASC_ZERO + {4'h0, d};
    endfunction

    function automatic logic [31:0] status_str(input state_e s);
        case (s)
            ST_RUN:  return STR_RUN;
            ST_LAP:  return STR_LAP;
            ST_STOP: return STR_STOP;
            default: return STR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_counter.sv
// 100 Hz prescaler plus saturating BCD MM:SS.CC counter.
// Latency: first hundredth lands CLK_HZ/100 cycles after restart; time updates on the tick edge.
// Backpressure: none; run/clear/restart are level controls sampled every cycle.
module stopwatch_counter
    import mode_stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        clear,
    input  logic        restart,
    output logic [23:0] time_o,
    output logic        sat_o
);

    localparam int unsigned DIV = CLK_HZ / 100;
    localparam int PW = $clog2(DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic          tick;
    logic          at_max;

    assign tick   = run && (presc_q == PW'(DIV - 1));
    assign at_max = (time_q == TIME_MAX);
    assign sat_o  = tick && at_max;
    assign time_o = time_q;

    // Prescaler runs only while counting; a tick at full scale leaves time unchanged.
    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        if (clear) begin
            presc_d = '0;
            time_d  = '0;
        end else begin
            if (restart) begin
                presc_d = '0;
            end else if (run) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick && !at_max) begin
                time_d = bcd_time_inc(time_q);
            end
        end
    end

    // Prescaler and time registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            time_q  <= '0;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
        end
    end

endmodule

// File: rtl/mode_stopwatch.sv
// Stopwatch display mode: button edge detect, IDLE/RUN/LAP/STOP FSM, 2x16 ASCII character mux.
// Latency: press acts 2 edges after the input rises; out follows index by one edge. MODE_STOPWATCH_LAP_EN builds the lap feature.
// Backpressure: none; index is answered every cycle and presses are never queued.
module mode_stopwatch
    import mode_stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    input  logic [4:0] index,
    output logic [7:0] out,
    output logic       running
);

    logic [1:0]  sw_q, sw_prev_q;
    logic        start_p, lap_p;
    state_e      state_q, state_d;
    logic        running_q;
    logic [7:0]  out_q, char_d;
    logic [23:0] time_w, disp_time;
    logic        sat_w;
    logic        run, clear, restart;
    logic [31:0] status_w;
    logic        unused_sw;

    assign unused_sw = ^sw_in[3:2];

    // Start takes priority: a simultaneous lap press is dropped.
    assign start_p = sw_q[0] & ~sw_prev_q[0];
    assign lap_p   = sw_q[1] & ~sw_prev_q[1] & ~start_p;

    assign run     = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign clear   = (state_d == ST_IDLE);
    assign restart = (state_d == ST_RUN) && (state_q != ST_RUN);

    stopwatch_counter #(.CLK_HZ(CLK_HZ)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .clear   (clear),
        .restart (restart),
        .time_o  (time_w),
        .sat_o   (sat_w)
    );

`ifdef MODE_STOPWATCH_LAP_EN
    logic [23:0] lap_q;
    logic        lap_cap;
`endif

    // Next state; a saturating tick forces STOP like a stop press.
    always_comb begin
        state_d = state_q;
`ifdef MODE_STOPWATCH_LAP_EN
        lap_cap = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_p || sat_w) begin
                    state_d = ST_STOP;
                end
`ifdef MODE_STOPWATCH_LAP_EN
                else if (lap_p) begin
                    state_d = ST_LAP;
                    lap_cap = 1'b1;
                end
`endif
            end
`ifdef MODE_STOPWATCH_LAP_EN
            ST_LAP: begin
                if (start_p || sat_w) begin
                    state_d = ST_STOP;
                end else if (lap_p) begin
                    lap_cap = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (start_p)    state_d = ST_RUN;
                else if (lap_p) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MODE_STOPWATCH_LAP_EN
    // Lap register captures the pre-tick time and clears with the stopwatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q <= '0;
        end else if (state_d == ST_IDLE) begin
            lap_q <= '0;
        end else if (lap_cap) begin
            lap_q <= time_w;
        end
    end
    assign disp_time = (state_q == ST_LAP) ? lap_q : time_w;
`else
    assign disp_time = time_w;
`endif

    assign status_w = status_str(state_q);

    // Character for the scanned position; unused positions read as spaces.
    always_comb begin
        char_d = ASC_SPACE;
        if (index < 5'd10) begin
            char_d = STR_TITLE[7'd72 - {index[3:0], 3'b000} +: 8];
        end else if (index >= IDX_STATUS && index < IDX_STATUS + 5'd4) begin
            char_d = status_w[5'd24 - {index[1:0], 3'b000} +: 8];
        end else begin
            case (index)
                IDX_MM:         char_d = digit_char(disp_time[23:20]);
                IDX_MM + 5'd1:  char_d = digit_char(disp_time[19:16]);
                IDX_MM + 5'd2:  char_d = ASC_COLON;
                IDX_SS:         char_d = digit_char(disp_time[15:12]);
                IDX_SS + 5'd1:  char_d = digit_char(disp_time[11:8]);
                IDX_SS + 5'd2:  char_d = ASC_DOT;
                IDX_CC:         char_d = digit_char(disp_time[7:4]);
                IDX_CC + 5'd1:  char_d = digit_char(disp_time[3:0]);
                default:        char_d = ASC_SPACE;
            endcase
        end
    end

    // Edge-detect registers, state, running flag and output character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_q      <= '0;
            sw_prev_q <= '0;
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            out_q     <= ASC_SPACE;
        end else begin
            sw_q      <= sw_in[1:0];
            sw_prev_q <= sw_q;
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN) || (state_d == ST_LAP);
            out_q     <= char_d;
        end
    end

    assign out     = out_q;
    assign running = running_q;

endmodule

// File: tb/tb_mode_stopwatch.sv
// Directed bench for mode_stopwatch at CLK_HZ = 1000 (10 cycles per hundredth).
// Latency: presses land 2 edges after drive; out is read one edge after index.
// Backpressure: n/a.
module tb_mode_stopwatch;

    logic       clk;
    logic       rst;
    logic [3:0] sw_in;
    logic [4:0] index;
    logic [7:0] out;
    logic       running;

    int vec_cnt = 0;
    int err_cnt = 0;

    mode_stopwatch #(.CLK_HZ(1000)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .index   (index),
        .out     (out),
        .running (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_run(input string tag, input logic exp);
        chk(tag, {7'd0, running}, {7'd0, exp});
    endtask

    // One cycle press pulse; the state changes on the second edge after the drive.
    task automatic press(input logic [3:0] bits);
        sw_in = bits;
        wait_cyc(1);
        sw_in = 4'd0;
    endtask

    // Full 32-character scan against the two expected lines.
    task automatic scan(input string tag, input string l1, input string l2);
        logic [7:0] e;
        for (int i = 0; i < 32; i++) begin
            index = 5'(i);
            wait_cyc(1);
            e = (i < 16) ? l1[i] : l2[i-16];
            chk($sformatf("%s[%0d]", tag, i), out, e);
        end
    endtask

    // Status field only (4 cycles), usable while the time is moving.
    task automatic chk_status(input string tag, input string s);
        for (int k = 0; k < 4; k++) begin
            index = 5'(12 + k);
            wait_cyc(1);
            chk($sformatf("%s[%0d]", tag, k), out, s[k]);
        end
    endtask

    initial begin
        rst   = 1'b0;
        sw_in = 4'd0;
        index = 5'd0;
        wait_cyc(3);
        chk("rst_out", out, 8'h20);
        chk_run("rst_running", 1'b0);
        rst = 1'b1;
        wait_cyc(1);
        scan("idle", "STOPWATCH   IDLE", "  00:00.00      ");
        chk_run("idle_running", 1'b0);

        // Start, run 1235 cycles from entry, stop: 123 hundredths (cc carry into ss).
        press(4'b0001);
        wait_cyc(2);
        chk_run("run_running", 1'b1);
        chk_status("run_status", "RUN ");
        wait_cyc(1228);
        press(4'b0001);
        wait_cyc(2);
        chk_run("stop_running", 1'b0);
        scan("stop123", "STOPWATCH   STOP", "  00:01.23      ");

        // ss 59 -> 00 carries into mm: 00:59.98 plus two ticks.
        force dut.u_cnt.time_q = 24'h005998;
        wait_cyc(1);
        release dut.u_cnt.time_q;
        press(4'b0001);
        wait_cyc(23);
        press(4'b0001);
        wait_cyc(2);
        scan("mmcarry", "STOPWATCH   STOP", "  01:00.00      ");

`ifdef MODE_STOPWATCH_LAP_EN
        // Lap at 25 hundredths, display frozen while counting, stop at 30.
        press(4'b0001);
        wait_cyc(255);
        press(4'b0010);
        wait_cyc(2);
        chk_run("lap_running", 1'b1);
        scan("lap", "STOPWATCH   LAP ", "  01:00.25      ");
        wait_cyc(14);
        press(4'b0001);
        wait_cyc(2);
        chk_run("lapstop_running", 1'b0);
        scan("lapstop", "STOPWATCH   STOP", "  01:00.30      ");
`else
        // Lap press in RUN is ignored; three ticks elapse before stop.
        press(4'b0001);
        wait_cyc(5);
        press(4'b0010);
        wait_cyc(2);
        chk_run("nolap_running", 1'b1);
        chk_status("nolap_status", "RUN ");
        wait_cyc(20);
        press(4'b0001);
        wait_cyc(2);
        scan("nolapstop", "STOPWATCH   STOP", "  01:00.03      ");
`endif

        // Lap in STOP clears back to IDLE.
        press(4'b0010);
        wait_cyc(2);
        chk_run("clear_running", 1'b0);
        scan("clear", "STOPWATCH   IDLE", "  00:00.00      ");

        // Start and lap together from IDLE: RUN, one tick, stop.
        press(4'b0011);
        wait_cyc(2);
        chk_run("both_idle_running", 1'b1);
        chk_status("both_idle_status", "RUN ");
        wait_cyc(8);
        press(4'b0001);
        wait_cyc(2);
        scan("both_idle", "STOPWATCH   STOP", "  00:00.01      ");

        // Start and lap together from STOP: resume without clearing.
        press(4'b0011);
        wait_cyc(2);
        chk_run("both_stop_running", 1'b1);
        chk_status("both_stop_status", "RUN ");
        wait_cyc(8);
        press(4'b0001);
        wait_cyc(2);
        scan("both_stop", "STOPWATCH   STOP", "  00:00.02      ");

        // Saturation: 99:59.98 ticks to 99:59.99, next tick holds and forces STOP.
        force dut.u_cnt.time_q = 24'h995998;
        wait_cyc(1);
        release dut.u_cnt.time_q;
        press(4'b0001);
        wait_cyc(2);
        chk_run("sat_pre_running", 1'b1);
        wait_cyc(30);
        chk_run("sat_running", 1'b0);
        scan("sat", "STOPWATCH   STOP", "  99:59.99      ");

        // Asynchronous reset while running.
        press(4'b0001);
        wait_cyc(2);
        index = 5'd18;
        wait_cyc(2);
        chk("prerst_mm", out, 8'h39);
        chk_run("prerst_running", 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out", out, 8'h20);
        chk_run("arst_running", 1'b0);
        #2;
        rst = 1'b1;
        wait_cyc(1);
        scan("postrst", "STOPWATCH   IDLE", "  00:00.00      ");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
